// File: rtl/conf_int_sub__serial__arch_agnos.sv
// Digit-serial configurable-precision integer subtractor.
// Only the top OP_BITWIDTH bits of each operand are used. The block processes DIGIT_WIDTH bits
// per cycle, LSB digit first. The difference is left-aligned in c, and its low bits are zero.
module conf_int_sub__serial__arch_agnos #(
    parameter int unsigned OP_BITWIDTH        = 16,
    parameter int unsigned DATA_PATH_BITWIDTH = 16,
    parameter int unsigned DIGIT_WIDTH        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic                          borrow,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int unsigned OW    = OP_BITWIDTH;
    localparam int unsigned DW    = DATA_PATH_BITWIDTH;
    localparam int unsigned DIG   = DIGIT_WIDTH;
    localparam int unsigned N     = OW / DIG;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((OW > DW) || ((OW % DIG) != 0)) begin : g_param_check
            $error("conf_int_sub: need OP_BITWIDTH <= DATA_PATH_BITWIDTH and DIGIT_WIDTH | OP_BITWIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [OW-1:0]    r_a;
    logic [OW-1:0]    r_b;
    logic [OW-1:0]    r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bin;
    logic [DW-1:0]    r_c;
    logic             r_borrow;

    logic             w_last;
    logic [DIG:0]     w_diff;
    logic [OW-1:0]    w_res_next;
    logic [DW-1:0]    w_c_next;

    assign w_last = (r_state == StCalc) && (r_cnt == CNT_W'(N - 1));

    // One digit of a - b - bin. Bit DIG of the (DIG+1)-bit difference is the borrow-out.
    assign w_diff = {1'b0, r_a[DIG-1:0]} - {1'b0, r_b[DIG-1:0]} - {{DIG{1'b0}}, r_bin};

    // The new digit enters the result from the MSB side. After N shifts the digits are in order.
    always_comb begin
        w_res_next = r_res >> DIG;
        w_res_next[OW-1 -: DIG] = w_diff[DIG-1:0];
        w_c_next = '0;
        w_c_next[DW-1 -: OW] = w_res_next;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (in_valid)  w_state_next = StCalc;
            StCalc: if (w_last)    w_state_next = StDone;
            StDone: if (out_ready) w_state_next = StIdle;
            default:               w_state_next = StIdle;
        endcase
    end

    // Datapath: capture the operands, shift one digit per cycle, and load the result on the last digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_c      <= '0;
            r_borrow <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a   <= a[DW-1 -: OW];
                        r_b   <= b[DW-1 -: OW];
                        r_bin <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                StCalc: begin
                    r_a   <= r_a >> DIG;
                    r_b   <= r_b >> DIG;
                    r_res <= w_res_next;
                    r_bin <= w_diff[DIG];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_c      <= w_c_next;
                        r_borrow <= w_diff[DIG];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign c         = r_c;
    assign borrow    = r_borrow;

endmodule

// File: tb/tb_conf_int_sub__serial__arch_agnos.sv
// Bench for conf_int_sub__serial__arch_agnos.
// Three instances cover OW16/D4, OW8/D4 and OW16/D16. Each result is checked against an
// arithmetic reference.
module tb_conf_int_sub__serial__arch_agnos;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        in_valid, out_ready;
    int          sel;

    logic        in_valid_q [3];
    logic        in_ready_q [3];
    logic [15:0] c_q        [3];
    logic        borrow_q   [3];
    logic        out_valid_q[3];

    logic [15:0] obs_c;
    logic        obs_borrow, obs_in_ready, obs_out_valid;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ow_of[3] = '{16, 8, 16};
    int          n_of [3] = '{4, 2, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < 3; k++) in_valid_q[k] = in_valid && (sel == k);
        obs_c         = c_q[sel];
        obs_borrow    = borrow_q[sel];
        obs_in_ready  = in_ready_q[sel];
        obs_out_valid = out_valid_q[sel];
    end

    conf_int_sub__serial__arch_agnos #(.OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(16), .DIGIT_WIDTH(4))
    u_d16 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid_q[0]), .in_ready(in_ready_q[0]),
        .c(c_q[0]), .borrow(borrow_q[0]), .out_valid(out_valid_q[0]), .out_ready(out_ready)
    );

    conf_int_sub__serial__arch_agnos #(.OP_BITWIDTH(8), .DATA_PATH_BITWIDTH(16), .DIGIT_WIDTH(4))
    u_d8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid_q[1]), .in_ready(in_ready_q[1]),
        .c(c_q[1]), .borrow(borrow_q[1]), .out_valid(out_valid_q[1]), .out_ready(out_ready)
    );

    conf_int_sub__serial__arch_agnos #(.OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(16), .DIGIT_WIDTH(16))
    u_w16 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid_q[2]), .in_ready(in_ready_q[2]),
        .c(c_q[2]), .borrow(borrow_q[2]), .out_valid(out_valid_q[2]), .out_ready(out_ready)
    );

    // Reference: truncate to the top ow bits, subtract modulo 2^ow, and left-align the result.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input int ow);
        longint unsigned ta, tb, m, d;
        ta = longint'(x) >> (16 - ow);
        tb = longint'(y) >> (16 - ow);
        m  = longint'(1) << ow;
        d  = ((ta + m - tb) % m) << (16 - ow);
        return {ta < tb, d[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one operation on instance sel. stall holds out_ready low in DONE while junk is offered.
    task automatic op(input logic [15:0] ia, input logic [15:0] ib, input int stall,
                      output int t_acc);
        logic [16:0] exp;
        int lat;
        exp = model(ia, ib, ow_of[sel]);
        out_ready = (stall == 0);
        chk("in_ready_before_accept", 32'(obs_in_ready), 32'd1);
        a = ia; b = ib; in_valid = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        in_valid = 1'b0;
        a = $urandom(); b = $urandom();
        chk("in_ready_in_calc", 32'(obs_in_ready), 32'd0);
        lat = 0;
        do begin
            if (lat > 0 || n_of[sel] > 0) begin
                @(posedge clk); #1;
            end
            lat++;
        end while (!obs_out_valid && lat < 64);
        chk("latency", 32'(lat), 32'(n_of[sel]));
        chk("c", 32'(obs_c), 32'(exp[15:0]));
        chk("borrow", 32'(obs_borrow), 32'(exp[16]));
        for (int i = 0; i < stall; i++) begin
            a = 16'h5555; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", 32'(obs_out_valid), 32'd1);
            chk("stall_in_ready", 32'(obs_in_ready), 32'd0);
            chk("stall_c", 32'(obs_c), 32'(exp[15:0]));
            chk("stall_borrow", 32'(obs_borrow), 32'(exp[16]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff_valid", 32'(obs_out_valid), 32'd0);
        chk("handoff_in_ready", 32'(obs_in_ready), 32'd1);
        chk("held_c", 32'(obs_c), 32'(exp[15:0]));
    endtask

    initial begin
        int t0, t1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 0; a = '0; b = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k; #0;
            chk("rst_in_ready", 32'(obs_in_ready), 32'd1);
            chk("rst_out_valid", 32'(obs_out_valid), 32'd0);
            chk("rst_c", 32'(obs_c), 32'd0);
            chk("rst_borrow", 32'(obs_borrow), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // OW16 / D4 directed cases
        sel = 0;
        op(16'h1234, 16'h0034, 0, t0);
        op(16'h0000, 16'h0001, 0, t0);
        op(16'hFFFF, 16'hFFFF, 0, t0);
        op(16'h9ABC, 16'h1111, 3, t0);
        op(16'h0042, 16'h0043, 0, t0);

        // Reset two cycles after accept aborts the operation.
        a = 16'h7777; b = 16'h1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(obs_out_valid), 32'd0);
        chk("abort_in_ready", 32'(obs_in_ready), 32'd1);
        chk("abort_c", 32'(obs_c), 32'd0);
        chk("abort_borrow", 32'(obs_borrow), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        op(16'h0010, 16'h0008, 0, t0);

        // OW8 / D4 directed cases
        sel = 1;
        op(16'h12FF, 16'h0101, 0, t0);
        op(16'h01AB, 16'h0200, 0, t0);

        // D16: back-to-back, accepts three cycles apart
        sel = 2;
        op(16'h8000, 16'h8000, 0, t0);
        op(16'h0003, 16'h0005, 0, t1);
        chk("accept_spacing", 32'(t1 - t0), 32'd3);

        // Randomized operations with random backpressure on every configuration
        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int i = 0; i < 12; i++) begin
                op(16'($urandom()), 16'($urandom()), int'($urandom_range(0, 2)), t0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
